// File: rtl/control_sequencer.sv
// control_sequencer
// Multi-cycle control unit for the ALUSystem datapath. A single FSM walks
// INIT -> FETCH_L -> FETCH_H -> EXEC1 [-> EXEC2] and back to FETCH_L, and
// drives every datapath control field from a register.
//
// Timing: the control vector for a state is computed on the edge that enters
// that state and is registered alongside the state code. T_State and the
// control outputs therefore always describe the same cycle. EXEC1 decodes
// IR_Out and ALU_ZCNO as they stand on the edge entering EXEC1. EXEC2 decodes
// IR_Out as it stands on the edge entering EXEC2.
//
// After Reset is released, the first rising edge stays in INIT and issues the
// clear vector. The next edge moves to FETCH_L.
//
// Optional build macro: CU_SINGLE_STEP_EN
//   defined   : adds the Step input and the PAUSE state. Every completed
//               instruction parks in PAUSE (idle vector) until Step=1 is
//               seen on a rising edge.
//   undefined : no Step port; completed instructions go straight to FETCH_L.
//
// Handshake: there is no valid/ready pair on this block. Step is a level that
// is sampled only in PAUSE: PAUSE is left on the first rising edge where
// Step=1. Step is ignored in every other state.
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR_Out,
  input  logic [3:0]  ALU_ZCNO,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  T_State
);

  // State codes are visible on T_State, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH_L = 3'd1,
    ST_FETCH_H = 3'd2,
    ST_EXEC1   = 3'd3,
    ST_EXEC2   = 3'd4,
`ifdef CU_SINGLE_STEP_EN
    ST_PAUSE   = 3'd5,
`endif
    ST_HALT    = 3'd6
  } state_t;

  // One record holds every registered control field. The field order matches
  // the output port list.
  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_rsel;
    logic [3:0] rf_tsel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_outa_sel;
    logic [1:0] arf_outb_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_rsel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  // Idle vector: nothing is written, and memory is deselected (CS is
  // active-low).
  localparam ctrl_t CTRL_IDLE = '{3'd0, 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 2'd0, 2'd0,
                                  2'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1,
                                  2'd0, 2'd0, 1'b0};

  // Register-file and address-register function codes.
  localparam logic [1:0] FUN_INC   = 2'b01;
  localparam logic [1:0] FUN_LOAD  = 2'b10;
  localparam logic [1:0] FUN_CLEAR = 2'b11;

  // Mux A / Mux B source codes.
  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IR  = 2'b10;

  // Opcodes.
  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ST  = 4'd1;
  localparam logic [3:0] OP_ALU = 4'd2;
  localparam logic [3:0] OP_BRA = 4'd3;
  localparam logic [3:0] OP_BNE = 4'd4;
  localparam logic [3:0] OP_HLT = 4'd5;

  // Instruction fields.
  logic [3:0] opcode;
  logic [1:0] rx;
  logic [1:0] ry;
  logic       mode_direct;
  logic [3:0] alu_fn;
  logic [3:0] rx_onehot;
  logic       unused_inputs;

  assign opcode      = IR_Out[15:12];
  assign rx          = IR_Out[11:10];
  assign ry          = IR_Out[1:0];
  assign mode_direct = IR_Out[8];
  assign alu_fn      = IR_Out[7:4];

  // Write enables for R1..R4. R1 is bit 3, so register Rx is bit (3 - rx).
  assign rx_onehot     = 4'b1000 >> rx;
  assign unused_inputs = ^{IR_Out[9], IR_Out[3:2], ALU_ZCNO[2:0]};

  // Registered state and outputs.
  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   halted_q, halted_d;
  logic   init_done_q, init_done_d;

  // Pre-built vectors used by the next-state logic.
  ctrl_t  exec1_ctrl;
  ctrl_t  exec2_ctrl;
  logic   needs_exec2;
  ctrl_t  done_ctrl;
  state_t done_state;

  // Fetch vector: read memory at PC into one IR half and increment PC.
  function automatic ctrl_t ctrl_fetch(input logic high_half);
    ctrl_t c;
    c              = CTRL_IDLE;
    c.arf_outb_sel = 2'b00;
    c.mem_cs       = 1'b0;
    c.ir_enable    = 1'b1;
    c.ir_funsel    = FUN_LOAD;
    c.ir_lh        = high_half;
    c.arf_rsel     = 4'b1000;
    c.arf_fun_sel  = FUN_INC;
    return c;
  endfunction

  // Load AR with the address field IR[7:0].
  function automatic ctrl_t ctrl_ar_load();
    ctrl_t c;
    c             = CTRL_IDLE;
    c.mux_b_sel   = MUX_IR;
    c.arf_rsel    = 4'b0100;
    c.arf_fun_sel = FUN_LOAD;
    return c;
  endfunction

  // Load PC with the target field IR[7:0].
  function automatic ctrl_t ctrl_branch();
    ctrl_t c;
    c             = CTRL_IDLE;
    c.mux_b_sel   = MUX_IR;
    c.arf_rsel    = 4'b1000;
    c.arf_fun_sel = FUN_LOAD;
    return c;
  endfunction

  // Where a completed instruction goes next.
  always_comb begin
`ifdef CU_SINGLE_STEP_EN
    done_state = ST_PAUSE;
    done_ctrl  = CTRL_IDLE;
`else
    done_state = ST_FETCH_L;
    done_ctrl  = ctrl_fetch(1'b0);
`endif
  end

  // EXEC1 decode: one cycle of work per opcode. Unused opcodes fall through
  // to the idle vector (NOP).
  always_comb begin
    exec1_ctrl = CTRL_IDLE;
    case (opcode)
      OP_LD: begin
        if (mode_direct) begin
          exec1_ctrl = ctrl_ar_load();
        end else begin
          exec1_ctrl.mux_a_sel  = MUX_IR;
          exec1_ctrl.rf_rsel    = rx_onehot;
          exec1_ctrl.rf_fun_sel = FUN_LOAD;
        end
      end
      OP_ST: exec1_ctrl = ctrl_ar_load();
      OP_ALU: begin
        exec1_ctrl.rf_outa_sel = {1'b1, rx};
        exec1_ctrl.rf_outb_sel = {1'b1, ry};
        exec1_ctrl.alu_fun_sel = alu_fn;
        exec1_ctrl.mux_a_sel   = MUX_ALU;
        exec1_ctrl.rf_rsel     = rx_onehot;
        exec1_ctrl.rf_fun_sel  = FUN_LOAD;
      end
      OP_BRA: exec1_ctrl = ctrl_branch();
      // BNE branches only when the Z flag is clear.
      OP_BNE: if (!ALU_ZCNO[3]) exec1_ctrl = ctrl_branch();
      default: exec1_ctrl = CTRL_IDLE;
    endcase
  end

  // EXEC2 decode: the memory access of LD direct and ST, both addressed by AR.
  always_comb begin
    exec2_ctrl  = CTRL_IDLE;
    needs_exec2 = 1'b0;
    if (opcode == OP_LD && mode_direct) begin
      needs_exec2             = 1'b1;
      exec2_ctrl.arf_outb_sel = 2'b01;
      exec2_ctrl.mem_cs       = 1'b0;
      exec2_ctrl.mux_a_sel    = MUX_MEM;
      exec2_ctrl.rf_rsel      = rx_onehot;
      exec2_ctrl.rf_fun_sel   = FUN_LOAD;
    end else if (opcode == OP_ST) begin
      // Rx passes through the ALU unchanged to the memory data input.
      needs_exec2             = 1'b1;
      exec2_ctrl.rf_outa_sel  = {1'b1, rx};
      exec2_ctrl.mux_c_sel    = 1'b0;
      exec2_ctrl.alu_fun_sel  = 4'b0000;
      exec2_ctrl.arf_outb_sel = 2'b01;
      exec2_ctrl.mem_cs       = 1'b0;
      exec2_ctrl.mem_wr       = 1'b1;
    end
  end

  // Next state, and the control vector that will be registered with it.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = CTRL_IDLE;
    init_done_d = 1'b1;
    case (state_q)
      ST_INIT: begin
        if (!init_done_q) begin
          // First edge after reset: issue the clear of all registers.
          state_d            = ST_INIT;
          ctrl_d.rf_rsel     = 4'b1111;
          ctrl_d.rf_fun_sel  = FUN_CLEAR;
          ctrl_d.arf_rsel    = 4'b1110;
          ctrl_d.arf_fun_sel = FUN_CLEAR;
        end else begin
          state_d = ST_FETCH_L;
          ctrl_d  = ctrl_fetch(1'b0);
        end
      end
      ST_FETCH_L: begin
        state_d = ST_FETCH_H;
        ctrl_d  = ctrl_fetch(1'b1);
      end
      ST_FETCH_H: begin
        state_d = ST_EXEC1;
        ctrl_d  = exec1_ctrl;
      end
      ST_EXEC1: begin
        if (opcode == OP_HLT) begin
          state_d = ST_HALT;
          ctrl_d  = CTRL_IDLE;
        end else if (needs_exec2) begin
          state_d = ST_EXEC2;
          ctrl_d  = exec2_ctrl;
        end else begin
          state_d = done_state;
          ctrl_d  = done_ctrl;
        end
      end
      ST_EXEC2: begin
        state_d = done_state;
        ctrl_d  = done_ctrl;
      end
`ifdef CU_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (Step) begin
          state_d = ST_FETCH_L;
          ctrl_d  = ctrl_fetch(1'b0);
        end else begin
          state_d = ST_PAUSE;
          ctrl_d  = CTRL_IDLE;
        end
      end
`endif
      // HALT is left only through Reset.
      ST_HALT: begin
        state_d = ST_HALT;
        ctrl_d  = CTRL_IDLE;
      end
      default: begin
        state_d     = ST_INIT;
        ctrl_d      = CTRL_IDLE;
        init_done_d = 1'b0;
      end
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // State, control vector and status flops. Reset forces INIT with the idle
  // vector.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_INIT;
      ctrl_q      <= CTRL_IDLE;
      halted_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      halted_q    <= halted_d;
      init_done_q <= init_done_d;
    end
  end

  assign RF_OutASel  = ctrl_q.rf_outa_sel;
  assign RF_OutBSel  = ctrl_q.rf_outb_sel;
  assign RF_FunSel   = ctrl_q.rf_fun_sel;
  assign RF_RSel     = ctrl_q.rf_rsel;
  assign RF_TSel     = ctrl_q.rf_tsel;
  assign ALU_FunSel  = ctrl_q.alu_fun_sel;
  assign ARF_OutASel = ctrl_q.arf_outa_sel;
  assign ARF_OutBSel = ctrl_q.arf_outb_sel;
  assign ARF_FunSel  = ctrl_q.arf_fun_sel;
  assign ARF_RSel    = ctrl_q.arf_rsel;
  assign IR_LH       = ctrl_q.ir_lh;
  assign IR_Enable   = ctrl_q.ir_enable;
  assign IR_Funsel   = ctrl_q.ir_funsel;
  assign Mem_WR      = ctrl_q.mem_wr;
  assign Mem_CS      = ctrl_q.mem_cs;
  assign MuxASel     = ctrl_q.mux_a_sel;
  assign MuxBSel     = ctrl_q.mux_b_sel;
  assign MuxCSel     = ctrl_q.mux_c_sel;
  assign Halted      = halted_q;
  assign T_State     = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Directed bench for control_sequencer. Each entry in exp_q is
// {T_State, Halted, control fields}, with the fields in output-port order.
// Build with CU_SINGLE_STEP_EN defined to cover the PAUSE / Step behaviour.
module tb_control_sequencer;

  // Clock and reset
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IR_Out;
  logic [3:0]  ALU_ZCNO;
`ifdef CU_SINGLE_STEP_EN
  logic        Step;
`endif

  always #5 Clock = ~Clock;

  logic [2:0] RF_OutASel, RF_OutBSel, T_State;
  logic [1:0] RF_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel, MuxASel, MuxBSel;
  logic [3:0] RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel;
  logic       IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ALU_ZCNO(ALU_ZCNO),
`ifdef CU_SINGLE_STEP_EN
    .Step(Step),
`endif
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .Halted(Halted), .T_State(T_State)
  );

  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_rsel;
    logic [3:0] rf_tsel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_outa_sel;
    logic [1:0] arf_outb_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_rsel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } vec_t;

  wire [40:0] obs_vec = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
                         ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel, IR_LH, IR_Enable,
                         IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};

  // Scoreboard
  logic [44:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [44:0] got, input logic [44:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control vectors
  function automatic vec_t v_idle();
    vec_t v;
    v        = '0;
    v.mem_cs = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_init();
    vec_t v;
    v             = v_idle();
    v.rf_rsel     = 4'b1111;
    v.rf_fun_sel  = 2'b11;
    v.arf_rsel    = 4'b1110;
    v.arf_fun_sel = 2'b11;
    return v;
  endfunction

  function automatic vec_t v_fetch(input logic lh);
    vec_t v;
    v             = v_idle();
    v.mem_cs      = 1'b0;
    v.ir_enable   = 1'b1;
    v.ir_funsel   = 2'b10;
    v.ir_lh       = lh;
    v.arf_rsel    = 4'b1000;
    v.arf_fun_sel = 2'b01;
    return v;
  endfunction

  function automatic vec_t v_ld_imm(input logic [3:0] rsel);
    vec_t v;
    v            = v_idle();
    v.mux_a_sel  = 2'b10;
    v.rf_rsel    = rsel;
    v.rf_fun_sel = 2'b10;
    return v;
  endfunction

  function automatic vec_t v_ar_load();
    vec_t v;
    v             = v_idle();
    v.mux_b_sel   = 2'b10;
    v.arf_rsel    = 4'b0100;
    v.arf_fun_sel = 2'b10;
    return v;
  endfunction

  function automatic vec_t v_ld_mem(input logic [3:0] rsel);
    vec_t v;
    v              = v_idle();
    v.arf_outb_sel = 2'b01;
    v.mem_cs       = 1'b0;
    v.mux_a_sel    = 2'b01;
    v.rf_rsel      = rsel;
    v.rf_fun_sel   = 2'b10;
    return v;
  endfunction

  function automatic vec_t v_st(input logic [2:0] outa);
    vec_t v;
    v              = v_idle();
    v.rf_outa_sel  = outa;
    v.arf_outb_sel = 2'b01;
    v.mem_cs       = 1'b0;
    v.mem_wr       = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_alu(input logic [2:0] outa, input logic [2:0] outb,
                                 input logic [3:0] fn, input logic [3:0] rsel);
    vec_t v;
    v             = v_idle();
    v.rf_outa_sel = outa;
    v.rf_outb_sel = outb;
    v.alu_fun_sel = fn;
    v.rf_rsel     = rsel;
    v.rf_fun_sel  = 2'b10;
    return v;
  endfunction

  function automatic vec_t v_branch();
    vec_t v;
    v             = v_idle();
    v.mux_b_sel   = 2'b10;
    v.arf_rsel    = 4'b1000;
    v.arf_fun_sel = 2'b10;
    return v;
  endfunction

  // Driver tasks
  task automatic push(input logic [2:0] t, input logic h, input vec_t v);
    exp_q.push_back({t, h, v});
  endtask

  // One rising edge per queued entry; outputs are sampled 1 ns after the edge.
  task automatic run_cycles(input string tag);
    logic [44:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge Clock);
      #1;
      check_eq(tag, {T_State, Halted, obs_vec}, e);
    end
  endtask

  // Called while the sequencer is in FETCH_L. The operands stay stable until
  // the next instruction is started.
  task automatic start_instr(input logic [15:0] ir, input logic [3:0] zcno);
    IR_Out   = ir;
    ALU_ZCNO = zcno;
  endtask

  // Step from the end of an instruction to the next FETCH_L.
  task automatic to_fetch(input int hold);
`ifdef CU_SINGLE_STEP_EN
    for (int i = 0; i <= hold; i++) push(3'd5, 1'b0, v_idle());
    run_cycles("pause_hold");
    Step = 1'b1;
    push(3'd1, 1'b0, v_fetch(1'b0));
    run_cycles("pause_exit");
    Step = 1'b0;
`else
    if (hold < 0) $display("note: negative hold %0d", hold);
    push(3'd1, 1'b0, v_fetch(1'b0));
    run_cycles("next_fetch_l");
`endif
  endtask

  initial begin
    IR_Out   = 16'h0425;
    ALU_ZCNO = 4'b0000;
`ifdef CU_SINGLE_STEP_EN
    Step     = 1'b0;
`endif
    repeat (3) @(posedge Clock);
    #1;
    check_eq("reset_idle", {T_State, Halted, obs_vec}, {3'd0, 1'b0, v_idle()});

    // Reset release: one INIT cycle, then FETCH_L.
    @(negedge Clock);
    Reset = 1'b1;
    push(3'd0, 1'b0, v_init());
    push(3'd1, 1'b0, v_fetch(1'b0));
    run_cycles("init_seq");

    // LD R2, #0x25
    start_instr(16'h0425, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_ld_imm(4'b0100));
    run_cycles("ld_imm");
    to_fetch(0);

    // LD R4, [0x33]
    start_instr(16'h0D33, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_ar_load());
    push(3'd4, 1'b0, v_ld_mem(4'b0001));
    run_cycles("ld_direct");
    to_fetch(0);

    // ST R3, [0x40]
    start_instr(16'h1840, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_ar_load());
    push(3'd4, 1'b0, v_st(3'b110));
    run_cycles("st");
    to_fetch(0);

    // ALU: R4 <- R4 fn7 R3
    start_instr(16'h2C72, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_alu(3'b111, 3'b110, 4'b0111, 4'b0001));
    run_cycles("alu");
    to_fetch(0);

    // BRA 0x55
    start_instr(16'h3055, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_branch());
    run_cycles("bra");
    to_fetch(0);

    // BNE with Z set: not taken
    start_instr(16'h4010, 4'b1000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_idle());
    run_cycles("bne_z1");
    to_fetch(0);

    // BNE with Z clear: taken
    start_instr(16'h4010, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_branch());
    run_cycles("bne_z0");
    to_fetch(0);

    // NOP (opcode 7); in single-step builds, hold Step low for 10 cycles.
    start_instr(16'h7FFF, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_idle());
    run_cycles("nop");
    to_fetch(10);

    // HLT, then 20 cycles parked in HALT
    start_instr(16'h5000, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_idle());
    for (int i = 0; i < 20; i++) push(3'd6, 1'b1, v_idle());
    run_cycles("halt");

    // Asynchronous reset from HALT, mid-cycle
    #3;
    Reset = 1'b0;
    #1;
    check_eq("halt_reset", {T_State, Halted, obs_vec}, {3'd0, 1'b0, v_idle()});
    @(negedge Clock);
    Reset = 1'b1;
    push(3'd0, 1'b0, v_init());
    push(3'd1, 1'b0, v_fetch(1'b0));
    run_cycles("init_after_halt");

    // Asynchronous reset in the middle of a ST instruction
    start_instr(16'h1840, 4'b0000);
    push(3'd2, 1'b0, v_fetch(1'b1));
    push(3'd3, 1'b0, v_ar_load());
    run_cycles("st_partial");
    #2;
    Reset = 1'b0;
    #1;
    check_eq("mid_instr_reset", {T_State, Halted, obs_vec}, {3'd0, 1'b0, v_idle()});
    @(negedge Clock);
    Reset = 1'b1;
    push(3'd0, 1'b0, v_init());
    push(3'd1, 1'b0, v_fetch(1'b0));
    run_cycles("init_after_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-003 IR_Out  input  16  instruction register contents: [15:12] opcode, [11:10] Rx, [8] mode (0 immediate, 1 direct), [7:4] ALU function, [1:0] Ry, [7:0] address/immediate.
REQ-004 ALU_ZCNO  input  4  ALU flags {Z,C,N,O}.
REQ-005 Step  input  1  single-step advance pulse; present only with CU_SINGLE_STEP_EN.
REQ-006 Control outputs, registered, widths as ALUSystem ports: RF_OutASel 3, RF_OutBSel 3, RF_FunSel 2, RF_RSel 4, RF_TSel 4, ALU_FunSel 4, ARF_OutASel 2, ARF_OutBSel 2, ARF_FunSel 2, ARF_RSel 4, IR_LH 1, IR_Enable 1, IR_Funsel 2, Mem_WR 1, Mem_CS 1, MuxASel 2, MuxBSel 2, MuxCSel 1.
REQ-007 Halted  output  1  high while in HALT; T_State  output  3  current state code.

Function
REQ-008 Encodings: FunSel 00 dec, 01 inc, 10 load, 11 clear; RSel/TSel one-hot write enables; RF_OutxSel 3'b1xx selects R(xx+1); ARF_RSel bit3 PC, bit2 AR, bit1 SP; ARF_OutBSel 00 PC, 01 AR; Mem_CS active-low, Mem_WR 1 write; MuxA/MuxB 00 ALU, 01 Mem, 10 IR[7:0], 11 ARF OutA; ALU_FunSel 0000 passes A.
REQ-009 Idle vector (all enables 0, Mem_CS=1, Mem_WR=0, other fields 0) in every state/field not listed below.
REQ-010 States: INIT(0), FETCH_L(1), FETCH_H(2), EXEC1(3), EXEC2(4), PAUSE(5), HALT(6); one cycle per state except PAUSE/HALT.
REQ-011 INIT: RF_RSel=1111, RF_FunSel=11, ARF_RSel=1110, ARF_FunSel=11; next FETCH_L.
REQ-012 FETCH_L: ARF_OutBSel=00, Mem_CS=0, IR_Enable=1, IR_Funsel=10, IR_LH=0, ARF_RSel=1000, ARF_FunSel=01; next FETCH_H.
REQ-013 FETCH_H: as FETCH_L with IR_LH=1; next EXEC1.
REQ-014 Opcode 0 LD immediate (mode 0): EXEC1 MuxASel=10, RF_RSel one-hot Rx, RF_FunSel=10; done.
REQ-015 LD direct (mode 1): EXEC1 AR<-IR[7:0] (MuxBSel=10, ARF_RSel=0100, FunSel 10); EXEC2 ARF_OutBSel=01, Mem_CS=0, MuxASel=01, Rx load; done.
REQ-016 Opcode 1 ST: EXEC1 AR<-IR[7:0]; EXEC2 RF_OutASel=Rx, MuxCSel=0, ALU_FunSel=0000, ARF_OutBSel=01, Mem_CS=0, Mem_WR=1; done.
REQ-017 Opcode 2 ALU: EXEC1 RF_OutASel=Rx, RF_OutBSel=Ry, ALU_FunSel=IR[7:4], MuxASel=00, Rx load; done.
REQ-018 Opcode 3 BRA: EXEC1 MuxBSel=10, ARF_RSel=1000, ARF_FunSel=10; done. Opcode 4 BNE: same only if ALU_ZCNO[3]=0 sampled in EXEC1, else idle; done.
REQ-019 Opcode 5 HLT: next HALT; HALT holds idle vector, Halted=1, exits only via Reset.
REQ-020 Opcodes 6-15: EXEC1 idle (NOP); done.
REQ-021 "done" means next state FETCH_L (PAUSE when single-step compiled in).
REQ-022 Instruction latency: 3 cycles (LD imm, ALU, BRA, BNE, NOP), 4 cycles (LD direct, ST).

Reset
REQ-023 Reset low asynchronously forces state INIT, all outputs to idle vector, Halted=0, T_State=0, including mid-instruction and from HALT.
REQ-024 First rising edge after Reset deasserts executes INIT.

Configuration
REQ-025 CU_SINGLE_STEP_EN defined: Step port exists; "done" enters PAUSE (idle vector), leaving to FETCH_L on the first edge with Step=1; Step ignored in all other states.
REQ-026 CU_SINGLE_STEP_EN undefined: no Step port, no PAUSE state; "done" goes directly to FETCH_L.

Verification
REQ-027 Reset release -> INIT cycle shows RF_RSel=1111, ARF_RSel=1110, FunSel=11; then FETCH_L with Mem_CS=0, IR_LH=0.
REQ-028 IR_Out=16'h0425 (LD R2 imm 0x25) -> EXEC1 MuxASel=10, RF_RSel=0100, FunSel=10; FETCH_L 3 cycles after prior FETCH_L.
REQ-029 IR_Out=16'h1840 (ST R3 to 0x40) -> EXEC1 AR load, EXEC2 Mem_WR=1, Mem_CS=0, RF_OutASel=110; 4-cycle instruction.
REQ-030 IR_Out=16'h4010 with ALU_ZCNO=4'b1000 -> EXEC1 idle; with 4'b0000 -> ARF_RSel=1000, FunSel=10, MuxBSel=10.
REQ-031 IR_Out=16'h5000 -> HALT, Halted=1 for 20 cycles; Reset pulse low mid-cycle -> outputs idle immediately, Halted=0.
REQ-032 With CU_SINGLE_STEP_EN, NOP then Step held 0 for 10 cycles -> T_State=5 held; Step=1 one cycle -> FETCH_L next.
